// File: rtl/pipe_stage_regs_pkg.sv
// Shared widths, control-vector bit indices and stage payload types
// for the IF/ID, ID/EX and EX/MEM pipeline registers.
package pipe_stage_regs_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned RADDR_W   = 5;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned ID_CTRL_W = 9;
  localparam int unsigned EX_CTRL_W = 4;

  // ID control vector bit positions
  localparam int unsigned CTRL_REG_WRITE  = 8;
  localparam int unsigned CTRL_MEM_TO_REG = 7;
  localparam int unsigned CTRL_MEM_READ   = 6;
  localparam int unsigned CTRL_MEM_WRITE  = 5;
  localparam int unsigned CTRL_REG_DST    = 4;
  localparam int unsigned CTRL_ALU_SRC    = 3;
  localparam int unsigned CTRL_ALU_OP_HI  = 2;
  localparam int unsigned CTRL_ALU_OP_LO  = 1;
  localparam int unsigned CTRL_BRANCH     = 0;

  // EX/MEM control vector bit positions
  localparam int unsigned EXC_REG_WRITE  = 3;
  localparam int unsigned EXC_MEM_TO_REG = 2;
  localparam int unsigned EXC_MEM_READ   = 1;
  localparam int unsigned EXC_MEM_WRITE  = 0;

  localparam logic [ID_CTRL_W-1:0] CTRL_NOP = 9'd0;

  typedef struct packed {
    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] pc4;
  } ifid_t;

  typedef struct packed {
    logic [ID_CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0]    pc4;
    logic [DATA_W-1:0]    read_data1;
    logic [DATA_W-1:0]    read_data2;
    logic [IMM_W-1:0]     immediate;
    logic [RADDR_W-1:0]   rs;
    logic [RADDR_W-1:0]   rt;
    logic [RADDR_W-1:0]   rd;
  } idex_t;

  typedef struct packed {
    logic [EX_CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0]    alu_result;
    logic [DATA_W-1:0]    write_data;
    logic [RADDR_W-1:0]   dest_reg;
  } exmem_t;

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Stage-boundary bus: producer-side inputs and registered outputs of
// the three pipeline registers.
interface pipe_stage_regs_if;
  import pipe_stage_regs_pkg::*;

  logic                 ifid_hold;
  logic                 ifid_flush;
  logic [DATA_W-1:0]    if_instruction;
  logic [DATA_W-1:0]    if_pc4;
  logic [DATA_W-1:0]    ifid_instruction;
  logic [DATA_W-1:0]    ifid_pc4;

  logic [ID_CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0]    id_pc4;
  logic [DATA_W-1:0]    id_read_data1;
  logic [DATA_W-1:0]    id_read_data2;
  logic [IMM_W-1:0]     id_immediate;
  logic [RADDR_W-1:0]   id_rs;
  logic [RADDR_W-1:0]   id_rt;
  logic [RADDR_W-1:0]   id_rd;
  logic [ID_CTRL_W-1:0] idex_ctrl;
  logic [DATA_W-1:0]    idex_pc4;
  logic [DATA_W-1:0]    idex_read_data1;
  logic [DATA_W-1:0]    idex_read_data2;
  logic [IMM_W-1:0]     idex_immediate;
  logic [RADDR_W-1:0]   idex_rs;
  logic [RADDR_W-1:0]   idex_rt;
  logic [RADDR_W-1:0]   idex_rd;

  logic [EX_CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0]    ex_alu_result;
  logic [DATA_W-1:0]    ex_write_data;
  logic [RADDR_W-1:0]   ex_dest_reg;
  logic [EX_CTRL_W-1:0] exmem_ctrl;
  logic [DATA_W-1:0]    exmem_alu_result;
  logic [DATA_W-1:0]    exmem_write_data;
  logic [RADDR_W-1:0]   exmem_dest_reg;

  modport master (
    output ifid_hold, ifid_flush, if_instruction, if_pc4,
    output id_ctrl, id_pc4, id_read_data1, id_read_data2, id_immediate,
    output id_rs, id_rt, id_rd,
    output ex_ctrl, ex_alu_result, ex_write_data, ex_dest_reg,
    input  ifid_instruction, ifid_pc4,
    input  idex_ctrl, idex_pc4, idex_read_data1, idex_read_data2,
    input  idex_immediate, idex_rs, idex_rt, idex_rd,
    input  exmem_ctrl, exmem_alu_result, exmem_write_data, exmem_dest_reg
  );

  modport slave (
    input  ifid_hold, ifid_flush, if_instruction, if_pc4,
    input  id_ctrl, id_pc4, id_read_data1, id_read_data2, id_immediate,
    input  id_rs, id_rt, id_rd,
    input  ex_ctrl, ex_alu_result, ex_write_data, ex_dest_reg,
    output ifid_instruction, ifid_pc4,
    output idex_ctrl, idex_pc4, idex_read_data1, idex_read_data2,
    output idex_immediate, idex_rs, idex_rt, idex_rd,
    output exmem_ctrl, exmem_alu_result, exmem_write_data, exmem_dest_reg
  );

endinterface

// File: rtl/pipe_reg_field.sv
// Generic pipeline register: sync clear, flush-to-zero, hold.
// Priority per edge is reset > flush > hold > load.
module pipe_reg_field
  import pipe_stage_regs_pkg::*;
#(
  parameter int unsigned DATA_W = pipe_stage_regs_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage MIPS core.
// Only IF/ID stalls or flushes; ID/EX bubbles arrive as a zeroed id_ctrl.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  pipe_stage_regs_if.slave bus
);

  ifid_t  ifid_d,  ifid_q;
  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;

  assign ifid_d = '{instruction: bus.if_instruction, pc4: bus.if_pc4};

  assign idex_d = '{
    ctrl:       bus.id_ctrl,
    pc4:        bus.id_pc4,
    read_data1: bus.id_read_data1,
    read_data2: bus.id_read_data2,
    immediate:  bus.id_immediate,
    rs:         bus.id_rs,
    rt:         bus.id_rt,
    rd:         bus.id_rd
  };

  assign exmem_d = '{
    ctrl:       bus.ex_ctrl,
    alu_result: bus.ex_alu_result,
    write_data: bus.ex_write_data,
    dest_reg:   bus.ex_dest_reg
  };

  pipe_reg_field #(.DATA_W($bits(ifid_t))) u_ifid (
    .clk   (clk),
    .reset (reset),
    .flush (bus.ifid_flush),
    .hold  (bus.ifid_hold),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  pipe_reg_field #(.DATA_W($bits(idex_t))) u_idex (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .hold  (1'b0),
    .d     (idex_d),
    .q     (idex_q)
  );

  pipe_reg_field #(.DATA_W($bits(exmem_t))) u_exmem (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .hold  (1'b0),
    .d     (exmem_d),
    .q     (exmem_q)
  );

  // Outputs are direct flop taps
  assign bus.ifid_instruction = ifid_q.instruction;
  assign bus.ifid_pc4         = ifid_q.pc4;

  assign bus.idex_ctrl        = idex_q.ctrl;
  assign bus.idex_pc4         = idex_q.pc4;
  assign bus.idex_read_data1  = idex_q.read_data1;
  assign bus.idex_read_data2  = idex_q.read_data2;
  assign bus.idex_immediate   = idex_q.immediate;
  assign bus.idex_rs          = idex_q.rs;
  assign bus.idex_rt          = idex_q.rt;
  assign bus.idex_rd          = idex_q.rd;

  assign bus.exmem_ctrl       = exmem_q.ctrl;
  assign bus.exmem_alu_result = exmem_q.alu_result;
  assign bus.exmem_write_data = exmem_q.write_data;
  assign bus.exmem_dest_reg   = exmem_q.dest_reg;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: vector table plus a hold/release
// sequence and control-bit spot checks.
module tb_pipe_stage_regs;
  import pipe_stage_regs_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pipe_stage_regs_if bus();

  pipe_stage_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hold;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [8:0]  id_ctrl;
    logic [31:0] id_pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  ex_ctrl;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dest;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset              = v.rst;
    bus.ifid_hold      = v.hold;
    bus.ifid_flush     = v.flush;
    bus.if_instruction = v.instr;
    bus.if_pc4         = v.pc4;
    bus.id_ctrl        = v.id_ctrl;
    bus.id_pc4         = v.id_pc4;
    bus.id_read_data1  = v.rd1;
    bus.id_read_data2  = v.rd2;
    bus.id_immediate   = v.imm;
    bus.id_rs          = v.rs;
    bus.id_rt          = v.rt;
    bus.id_rd          = v.rd;
    bus.ex_ctrl        = v.ex_ctrl;
    bus.ex_alu_result  = v.alu;
    bus.ex_write_data  = v.wdata;
    bus.ex_dest_reg    = v.dest;
  endtask

  // ID/EX and EX/MEM load every non-reset edge; IF/ID expectations are hand-written
  task automatic check_vec(input int i, input vec_t v);
    string s;
    s = $sformatf("v%0d", i);
    check({s, ".ifid_instruction"}, 64'(bus.ifid_instruction), 64'(v.exp_instr));
    check({s, ".ifid_pc4"},         64'(bus.ifid_pc4),         64'(v.exp_pc4));
    check({s, ".idex_ctrl"},        64'(bus.idex_ctrl),        v.rst ? 64'd0 : 64'(v.id_ctrl));
    check({s, ".idex_pc4"},         64'(bus.idex_pc4),         v.rst ? 64'd0 : 64'(v.id_pc4));
    check({s, ".idex_read_data1"},  64'(bus.idex_read_data1),  v.rst ? 64'd0 : 64'(v.rd1));
    check({s, ".idex_read_data2"},  64'(bus.idex_read_data2),  v.rst ? 64'd0 : 64'(v.rd2));
    check({s, ".idex_immediate"},   64'(bus.idex_immediate),   v.rst ? 64'd0 : 64'(v.imm));
    check({s, ".idex_rs"},          64'(bus.idex_rs),          v.rst ? 64'd0 : 64'(v.rs));
    check({s, ".idex_rt"},          64'(bus.idex_rt),          v.rst ? 64'd0 : 64'(v.rt));
    check({s, ".idex_rd"},          64'(bus.idex_rd),          v.rst ? 64'd0 : 64'(v.rd));
    check({s, ".exmem_ctrl"},       64'(bus.exmem_ctrl),       v.rst ? 64'd0 : 64'(v.ex_ctrl));
    check({s, ".exmem_alu_result"}, 64'(bus.exmem_alu_result), v.rst ? 64'd0 : 64'(v.alu));
    check({s, ".exmem_write_data"}, 64'(bus.exmem_write_data), v.rst ? 64'd0 : 64'(v.wdata));
    check({s, ".exmem_dest_reg"},   64'(bus.exmem_dest_reg),   v.rst ? 64'd0 : 64'(v.dest));
  endtask

  initial begin
    vec_t v;
    //        rst hold flush instr          pc4     id_ctrl id_pc4  rd1      rd2      imm       rs  rt  rd  exc   alu      wdata    dest  exp_instr      exp_pc4
    vecs[0]  = '{1, 1, 0, 32'hFFFFFFFF, 32'h1234, 9'h1FF, 32'h55, 32'h66,  32'h77,  16'hFFFF, 31, 30, 29, 4'hF, 32'h88,  32'h99,  5'd7, 32'h0,        32'h0};
    vecs[1]  = '{1, 0, 1, 32'h0BADF00D, 32'h40,   9'h1C8, 32'h44, 32'h1,   32'h2,   16'h1234,  1,  2,  3, 4'h5, 32'h3,   32'h4,   5'd9, 32'h0,        32'h0};
    vecs[2]  = '{0, 0, 0, 32'h8C030004, 32'h4,    9'h1C8, 32'h4,  32'h10,  32'h20,  16'h0004,  0,  3,  0, 4'h0, 32'h0,   32'h0,   5'd0, 32'h8C030004, 32'h4};
    vecs[3]  = '{0, 1, 0, 32'h00641020, 32'h8,    9'h182, 32'h8,  32'h3,   32'h4,   16'h1020,  3,  4,  2, 4'h8, 32'h7,   32'h3,   5'd2, 32'h8C030004, 32'h4};
    vecs[4]  = '{0, 1, 0, 32'h00641020, 32'h8,    9'h0A1, 32'hC,  32'hA5,  32'h5A,  16'hBEEF, 10, 11, 12, 4'h4, 32'h100, 32'h200, 5'd12, 32'h8C030004, 32'h4};
    vecs[5]  = '{0, 0, 0, 32'h00641020, 32'h8,    9'h111, 32'h10, 32'h1,   32'h2,   16'h8000, 17, 18, 19, 4'h9, 32'hFFFFFFFF, 32'h1, 5'd31, 32'h00641020, 32'h8};
    vecs[6]  = '{0, 1, 1, 32'h12345678, 32'hC,    9'h1C8, 32'h14, 32'h7,   32'h8,   16'h0001,  2,  2,  2, 4'h2, 32'h9,   32'hA,   5'd4, 32'h0,        32'h0};
    vecs[7]  = '{0, 0, 0, 32'hAABBCCDD, 32'h10,   CTRL_NOP, 32'h18, 32'd50, 32'h9,   16'h0020,  5,  6,  7, 4'h1, 32'h11,  32'h22,  5'd6, 32'hAABBCCDD, 32'h10};
    vecs[8]  = '{0, 0, 1, 32'h11111111, 32'h14,   9'h004, 32'h1C, 32'h0,   32'h0,   16'h0000,  0,  0,  0, 4'hA, 32'hC,   32'd99,  5'd3, 32'h0,        32'h0};
    vecs[9]  = '{1, 0, 0, 32'hFFFFFFFF, 32'hFF,   9'h1FF, 32'h20, 32'h1,   32'h1,   16'h00FF, 31, 31, 31, 4'hF, 32'h1,   32'h1,   5'd31, 32'h0,       32'h0};
    vecs[10] = '{0, 0, 0, 32'hDEADBEEF, 32'h18,   9'h1A3, 32'h24, 32'hCAFE, 32'hF00D, 16'h7FFF, 8,  9, 10, 4'h6, 32'h30,  32'h31,  5'd10, 32'hDEADBEEF, 32'h18};

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_vec(i, vecs[i]);
    end

    // Multi-cycle stall: IF/ID frozen for three edges, then updates one edge after release
    v = vecs[10];
    v.instr = 32'hCAFE0001; v.pc4 = 32'h40; v.hold = 1'b0;
    drive(v);
    @(posedge clk); #1;
    check("seq.load_instr", 64'(bus.ifid_instruction), 64'h00000000CAFE0001);
    bus.ifid_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.if_instruction = 32'h00641020 + 32'(c);
      bus.if_pc4         = 32'h44 + 32'(4 * c);
      @(posedge clk); #1;
      check($sformatf("seq.held_instr%0d", c), 64'(bus.ifid_instruction), 64'h00000000CAFE0001);
      check($sformatf("seq.held_pc4%0d", c),   64'(bus.ifid_pc4),         64'h40);
    end
    bus.ifid_hold = 1'b0;
    @(posedge clk); #1;
    check("seq.release_instr", 64'(bus.ifid_instruction), 64'h0000000000641022);
    check("seq.release_pc4",   64'(bus.ifid_pc4),         64'h4C);

    // Control bit placement: lw-style ID vector and RegWrite|MemRead on EX/MEM
    bus.id_ctrl = 9'b1_1_1_0_0_1_00_0;
    bus.ex_ctrl = 4'b1010;
    @(posedge clk); #1;
    check("bit.mem_read",   64'(bus.idex_ctrl[CTRL_MEM_READ]),   64'd1);
    check("bit.mem_write",  64'(bus.idex_ctrl[CTRL_MEM_WRITE]),  64'd0);
    check("bit.alu_src",    64'(bus.idex_ctrl[CTRL_ALU_SRC]),    64'd1);
    check("bit.ex_regwr",   64'(bus.exmem_ctrl[EXC_REG_WRITE]),  64'd1);
    check("bit.ex_memread", 64'(bus.exmem_ctrl[EXC_MEM_READ]),   64'd1);
    check("bit.ex_memwr",   64'(bus.exmem_ctrl[EXC_MEM_WRITE]),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Groups the three inter-stage pipeline registers of the 5-stage MIPS core: IF/ID, ID/EX and EX/MEM.
- Captures each stage's datapath and control outputs on the rising clock edge for the next stage.
- IF/ID supports hold (load-use stall) and flush (taken branch).
- ID/EX and EX/MEM load unconditionally every cycle; bubbles enter ID/EX through a zeroed control vector.

Parameters:
DATA_W, 32, width of instruction, PC+4, register-read and ALU data paths
RADDR_W, 5, register-specifier width (rs/rt/rd/dest)

Ports (each "a -> b" line is a registered input a and its output b):
clk  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous, active-high; clears every register to 0
ifid_hold  in  1  IF/ID keeps its current contents
ifid_flush  in  1  IF/ID loads zeros (nop)
if_instruction -> ifid_instruction  in->out  DATA_W  fetched instruction word
if_pc4 -> ifid_pc4  in->out  DATA_W  PC+4 of fetched instruction
id_ctrl -> idex_ctrl  in->out  9  {RegWrite[8], MemToReg[7], MemRead[6], MemWrite[5], RegDst[4], AluSrc[3], AluOp[2:1], Branch[0]}
id_pc4 -> idex_pc4  in->out  DATA_W  PC+4 forwarded from IF/ID
id_read_data1 -> idex_read_data1  in->out  DATA_W  register file port 1
id_read_data2 -> idex_read_data2  in->out  DATA_W  register file port 2
id_immediate -> idex_immediate  in->out  16  instr[15:0]; also carries shamt [10:6] and funct [5:0]
id_rs -> idex_rs, id_rt -> idex_rt, id_rd -> idex_rd  in->out  RADDR_W each  instr[25:21], [20:16], [15:11]
ex_ctrl -> exmem_ctrl  in->out  4  {RegWrite[3], MemToReg[2], MemRead[1], MemWrite[0]}
ex_alu_result -> exmem_alu_result  in->out  DATA_W  ALU result / memory address
ex_write_data -> exmem_write_data  in->out  DATA_W  forwarded rt value (store data)
ex_dest_reg -> exmem_dest_reg  in->out  RADDR_W  RegDst-selected destination register

Behaviour:
- All outputs come straight from flops; no combinational input-to-output path. Latency is 1 cycle per register.
- Reset: on a rising edge with reset=1, every output of all three registers becomes 0, regardless of hold or flush. Instruction 0 (sll $0,$0,0) is a nop, and all-zero control means no writes.
- IF/ID priority per edge: reset > flush > hold > load.
  - Flush loads instruction=0 and pc4=0.
  - Hold retains both fields.
  - Otherwise loads if_instruction and if_pc4.
  - Simultaneous flush and hold: flush wins (a taken branch overrides a stall).
- ID/EX: loads every non-reset edge, with no hold or flush input. A bubble is inserted by the upstream mux driving id_ctrl=0; the data fields still load normally.
- EX/MEM: loads every non-reset edge, with no hold or flush.
- Reset deasserted mid-stream: the first edge after deassertion loads inputs normally.
- No arithmetic: pure storage, with fields kept bit-exact at their widths.
- Power-up before the first reset is undefined; the bench must apply reset first.

Decomposition:
- Shared package holds:
  - DATA_W and RADDR_W defaults.
  - Bit-index constants for the 9-bit ID control vector and the 4-bit EX/MEM control vector.
  - CTRL_NOP = 9'd0.
- One natural sub-module, pipe_reg_field: a DATA_W-parameterised register with sync clear, flush-to-zero and hold enable. It is instantiated per field, or once per stage with concatenated fields.

Test Plan:
- Reset: drive non-zero inputs on every port and assert reset for 2 edges -> every output reads 0, including ifid_instruction=0 and idex_ctrl=9'd0.
- Normal flow: if_instruction=32'h8C030004, if_pc4=4, ifid_hold=ifid_flush=0 -> after 1 edge ifid_instruction=32'h8C030004 and ifid_pc4=4. Feed the ID inputs (id_ctrl=9'b1_1_1_0_0_1_00_0, id_rs=0, id_rt=3, id_immediate=4) -> after the next edge the idex_* fields match exactly.
- Hold: ifid holds 32'h8C030004; set hold=1 and present 32'h00641020 -> the output stays 32'h8C030004 for every held cycle and updates 1 edge after hold drops.
- Flush priority: hold=1 and flush=1 with valid inputs -> ifid_instruction=0 and ifid_pc4=0 after the edge.
- Bubble: id_ctrl=0 with id_rs=5 and id_read_data1=50 -> idex_ctrl=0 while idex_rs=5 and idex_read_data1=50.
- EX/MEM: ex_ctrl=4'b1010, ex_alu_result=32'h0000000C, ex_write_data=99, ex_dest_reg=3 -> all four appear after 1 edge. Asserting reset on the following edge zeroes them.
